ifu_prefetch: RTL
=================

Name: ifu_prefetch

Overview:
Instruction prefetch stage between a variable-latency instruction memory and the decode/controller path of the MIPS core. Keeps a running fetch PC, issues word fetches over a req/gnt/rvalid port, and buffers returned words with their PCs in a small FIFO. Decode consumes instructions through a valid/ready handshake. A redirect input (branch, j, jal, jr target) flushes the queue and drops any in-flight responses.

Parameters:
DEPTH, 4, FIFO entries; power of two, ≥2
MAX_OUT, 2, maximum accepted-but-unreturned memory requests; ≥1
RESET_PC, 32'h0000_3000, first fetch address after reset

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-low reset
redirect  in  1  one-cycle pulse: restart fetch at redirect_pc
redirect_pc  in  32  new fetch address; bits [1:0] ignored, forced to 0
imem_req  out  1  fetch request
imem_addr  out  32  word-aligned fetch address (= fetch_pc)
imem_gnt  in  1  request accepted this cycle
imem_rvalid  in  1  response word valid; responses return in request order
imem_rdata  in  32  response word
ins_valid  out  1  insout/ins_pc valid
ins_ready  in  1  decode accepts the head entry
insout  out  32  instruction word at FIFO head
ins_pc  out  32  PC of insout

Behaviour:
- Reset (rst=0, asynchronous): fetch_pc=RESET_PC, FIFO empty, outstanding=0, discard=0. imem_req=0, ins_valid=0, insout=0, ins_pc=0.
- live = outstanding − discard. credit_ok = (fifo_count + live < DEPTH) && (outstanding < MAX_OUT).
- imem_req = rst && credit_ok && !redirect (combinational). imem_addr = fetch_pc.
- Request accepted when imem_req && imem_gnt: fetch_pc += 4 (wraps mod 2^32), outstanding += 1. Without gnt, req and addr stay stable until gnt or redirect.
- Response (imem_rvalid while outstanding>0): outstanding −= 1.
  - If discard>0: discard −= 1 and drop the word.
  - Otherwise push {rdata, pc_of_that_request} into the FIFO. The PC comes from an internal PC queue of depth MAX_OUT, filled on accept and popped on response.
- imem_rvalid while outstanding==0: ignored, with no state change.
- Pop: ins_valid && ins_ready. ins_valid = FIFO non-empty. insout/ins_pc are driven from the head entry and hold when not popped.
- Latency: a response in cycle N appears on ins_valid in cycle N+1.
- Redirect cycle:
  - FIFO is emptied, and any pop in that cycle is void.
  - No request is issued.
  - discard is set to the outstanding count after this cycle's response is applied. A response in the redirect cycle consumes one slot and is itself dropped.
  - From the next cycle, fetch_pc = {redirect_pc[31:2],2'b00}.
- Overflow safety: credit accounting guarantees that a kept response never finds the FIFO full. Simultaneous push and pop are legal at any count.
- Counter widths: outstanding and discard are clog2(MAX_OUT+1) bits. fifo_count is clog2(DEPTH+1) bits.
- Reset asserted mid-operation discards everything. In-flight memory responses after reset release are ignored because outstanding==0.

Optional Feature:
IFU_BYPASS_EN:
- Defined: when the FIFO is empty and a kept response arrives, insout/ins_pc/ins_valid are driven combinationally from imem_rdata/PC-queue head in the same cycle. If ins_ready=1 that cycle, the word is consumed and not pushed; otherwise it is pushed. Latency becomes 0 cycles. Redirect still suppresses bypass in its cycle.
- Undefined: 1-cycle registered latency as specified above.

Test Plan:
1. Reset release with imem_gnt=1, 1-cycle memory, ins_ready=1 → addresses 0x3000, 0x3004, 0x3008… in order; ins_pc tracks them; first ins_valid 2 cycles after first req.
2. ins_ready=0 with gnt=1 → exactly DEPTH=4 requests accepted, then imem_req=0; FIFO holds PCs 0x3000–0x300C; ins_ready=1 one cycle → head advances to 0x3004 and one new request for 0x3010 is issued.
3. Memory latency 5 cycles → never more than MAX_OUT=2 outstanding; imem_req drops while 2 are pending.
4. Redirect to 0x0000_4002 with 2 requests outstanding and 1 FIFO entry → ins_valid=0 next cycle; the 2 late responses are dropped; next imem_addr=0x4000; next delivered ins_pc=0x4000.
5. Redirect in the same cycle as imem_rvalid and ins_ready → that word is dropped, no pop counted, discard = remaining outstanding.
6. fetch_pc=0xFFFF_FFFC accepted → next imem_addr=0x0000_0000. Stray imem_rvalid with outstanding=0 → no FIFO change.

Source files
------------

// File: rtl/ifu_prefetch_if.sv
// ifu_prefetch_if: bundles the fetch-stage signals of ifu_prefetch.
//   redirect/redirect_pc : restart request from the branch/jump logic
//   imem_*               : req/gnt/rvalid instruction-memory port
//   ins_*/insout         : valid/ready instruction stream towards decode
// Modports:
//   master : the prefetch stage (drives imem_req/addr and the instruction stream)
//   slave  : the environment (memory, decode, redirect source)
interface ifu_prefetch_if;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        ins_valid;
    logic        ins_ready;
    logic [31:0] insout;
    logic [31:0] ins_pc;

    modport master (
        input  redirect, redirect_pc, imem_gnt, imem_rvalid, imem_rdata, ins_ready,
        output imem_req, imem_addr, ins_valid, insout, ins_pc
    );

    modport slave (
        output redirect, redirect_pc, imem_gnt, imem_rvalid, imem_rdata, ins_ready,
        input  imem_req, imem_addr, ins_valid, insout, ins_pc
    );
endinterface

// File: rtl/ifu_prefetch.sv
// ifu_prefetch: instruction prefetch stage.
// Keeps a running fetch PC, issues word fetches over a req/gnt/rvalid port and
// buffers returned words with their PCs in a DEPTH-entry FIFO read by decode.
// A redirect flushes the FIFO and drops every response still in flight.
// Ports:
//   clk    : clock, all state on the rising edge
//   rst    : asynchronous active-low reset
//   bus_io : ifu_prefetch_if.master (redirect, imem_*, ins_* signals)
// Build option:
//   IFU_BYPASS_EN : when defined, a kept response arriving at an empty FIFO is
//                   presented to decode in the same cycle (0-cycle latency).
//                   Undefined: responses appear one cycle after arrival.
module ifu_prefetch #(
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned MAX_OUT  = 2,
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input logic            clk,
    input logic            rst,
    ifu_prefetch_if.master bus_io
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned OW = $clog2(MAX_OUT + 1);
    localparam int unsigned QW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;

    // PC-queue pointers wrap at MAX_OUT, which need not be a power of two.
    function automatic logic [QW-1:0] pcq_inc(input logic [QW-1:0] p);
        return (p == QW'(MAX_OUT - 1)) ? '0 : p + 1'b1;
    endfunction

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [OW-1:0] out_q, out_d;
    logic [OW-1:0] disc_q, disc_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [QW-1:0] pcq_rd_q, pcq_rd_d;
    logic [QW-1:0] pcq_wr_q, pcq_wr_d;

    logic [31:0] fifo_ins_q [DEPTH];
    logic [31:0] fifo_pc_q  [DEPTH];
    logic [31:0] pcq_q      [MAX_OUT];

    logic [OW-1:0] live;
    logic          credit_ok;
    logic          req;
    logic          accept;
    logic          rsp;
    logic          keep;
    logic          head_valid;
    logic          byp;
    logic          push;
    logic          pop_fifo;

    always_comb begin
        // Requests whose responses will be kept still reserve a FIFO slot.
        live       = out_q - disc_q;
        credit_ok  = (32'(cnt_q) + 32'(live) < DEPTH) && (32'(out_q) < MAX_OUT);
        req        = rst && credit_ok && !bus_io.redirect;
        accept     = req && bus_io.imem_gnt;
        rsp        = bus_io.imem_rvalid && (out_q != '0);
        keep       = rsp && (disc_q == '0) && !bus_io.redirect;
        head_valid = (cnt_q != '0);

        bus_io.imem_req  = req;
        bus_io.imem_addr = fetch_pc_q;
        bus_io.ins_valid = head_valid;
        bus_io.insout    = head_valid ? fifo_ins_q[rd_ptr_q] : '0;
        bus_io.ins_pc    = head_valid ? fifo_pc_q[rd_ptr_q] : '0;
        byp              = 1'b0;
`ifdef IFU_BYPASS_EN
        if (keep && !head_valid) begin
            byp              = 1'b1;
            bus_io.ins_valid = 1'b1;
            bus_io.insout    = bus_io.imem_rdata;
            bus_io.ins_pc    = pcq_q[pcq_rd_q];
        end
`endif
        // A bypassed word taken by decode never enters the FIFO.
        pop_fifo = head_valid && bus_io.ins_ready && !bus_io.redirect;
        push     = keep && !(byp && bus_io.ins_ready);

        fetch_pc_d = fetch_pc_q;
        if (bus_io.redirect) begin
            fetch_pc_d = bus_io.redirect_pc & 32'hFFFF_FFFC;
        end else if (accept) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
        end

        out_d = out_q + OW'(accept) - OW'(rsp);
        if (bus_io.redirect) begin
            // Everything still outstanding after this cycle belongs to the old stream.
            disc_d = out_d;
        end else begin
            disc_d = disc_q - OW'(rsp && (disc_q != '0));
        end

        pcq_wr_d = accept ? pcq_inc(pcq_wr_q) : pcq_wr_q;
        pcq_rd_d = rsp ? pcq_inc(pcq_rd_q) : pcq_rd_q;

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (bus_io.redirect) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            wr_ptr_d = wr_ptr_q + AW'(push);
            rd_ptr_d = rd_ptr_q + AW'(pop_fifo);
            cnt_d    = cnt_q + CW'(push) - CW'(pop_fifo);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc_q <= RESET_PC;
            out_q      <= '0;
            disc_q     <= '0;
            cnt_q      <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            pcq_rd_q   <= '0;
            pcq_wr_q   <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            out_q      <= out_d;
            disc_q     <= disc_d;
            cnt_q      <= cnt_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            pcq_rd_q   <= pcq_rd_d;
            pcq_wr_q   <= pcq_wr_d;
        end
    end

    // Storage needs no reset: entries are only visible while counted as valid.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_ins_q[wr_ptr_q] <= bus_io.imem_rdata;
            fifo_pc_q[wr_ptr_q]  <= pcq_q[pcq_rd_q];
        end
        if (accept) begin
            pcq_q[pcq_wr_q] <= fetch_pc_q;
        end
    end
endmodule
